// File: rtl/dcache_pkg.sv
// Shared D-cache definitions: line geometry, address field slices and the refill state encoding.
`default_nettype none
package dcache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int BEAT_CW    = 3;

  localparam int TAG_HI   = 31;
  localparam int TAG_LO   = 13;
  localparam int INDEX_HI = 12;
  localparam int INDEX_LO = 5;
  localparam int WORD_HI  = 4;
  localparam int WORD_LO  = 2;

  // Width of the line number held by the refill sequencer (addr[31:5]).
  localparam int LINE_W = 32 - INDEX_LO;

  typedef enum logic [2:0] {
    RF_IDLE   = 3'd0,
    RF_INVAL  = 3'd1,
    RF_AR     = 3'd2,
    RF_DATA   = 3'd3,
    RF_DRAIN  = 3'd4,
    RF_COMMIT = 3'd5,
    RF_FAIL   = 3'd6
  } refill_state_e;

  function automatic logic [31:0] word_addr(input logic [LINE_W-1:0] line,
                                            input logic [BEAT_CW-1:0] word);
    return {line, word, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_mem_dcache_refill.sv
// D-cache line-refill sequencer: invalidate tag, 8-beat burst read, stream beats, commit tag.
// Macro DCACHE_REFILL_CRITICAL_WORD_FIRST_EN selects a wrapping burst starting at the missed word.
`default_nettype none
module execute_mem_dcache_refill
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  output logic        miss_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rresp_err,
  input  logic        mem_rlast,
  output logic        mem_rready,
  output logic        update_tag_en,
  output logic [31:0] update_tag_addr,
  output logic        update_tag_valid,
  output logic        update_data_valid,
  output logic [31:0] update_data_addr,
  output logic [3:0]  update_data_strb,
  output logic [31:0] update_data,
  input  logic        update_data_ready
);

  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(LINE_WORDS - 1);

  refill_state_e        state;
  logic [LINE_W-1:0]    line;
  logic [BEAT_CW-1:0]   word;
  logic [BEAT_CW-1:0]   count;
  logic [BEAT_CW-1:0]   start;
  logic [BEAT_CW-1:0]   widx;
  logic                 beat;
  logic                 beat_bad;

`ifdef DCACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start      = word;
  assign mem_araddr = word_addr(line, word);
`else
  assign start      = '0;
  assign mem_araddr = word_addr(line, '0);
`endif

  // count tracks beats received; widx wraps naturally in BEAT_CW bits.
  assign widx     = start + count;
  assign beat     = (state == RF_DATA) && mem_rvalid && update_data_ready;
  assign beat_bad = mem_rresp_err || (mem_rlast != (count == LAST_BEAT));

  assign mem_rready        = (state == RF_DATA) && update_data_ready;
  assign update_data_valid = (state == RF_DATA) && mem_rvalid;
  assign update_data_addr  = word_addr(line, widx);
  assign update_data_strb  = 4'hF;
  assign update_data       = mem_rdata;
  assign update_tag_addr   = word_addr(line, '0);

  always_ff @(posedge clk) begin
    refill_state_e nxt;
    if (!resetn) begin
      state            <= RF_IDLE;
      line             <= '0;
      word             <= '0;
      count            <= '0;
      miss_ready       <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      mem_arvalid      <= 1'b0;
      update_tag_en    <= 1'b0;
      update_tag_valid <= 1'b0;
    end else begin
      nxt = state;
      case (state)
        RF_IDLE: begin
          if (miss_valid) begin
            line  <= miss_addr[31:INDEX_LO];
            word  <= miss_addr[WORD_HI:WORD_LO];
            count <= '0;
            nxt   = RF_INVAL;
          end
        end
        RF_INVAL: nxt = RF_AR;
        RF_AR:    if (mem_arready) nxt = RF_DATA;
        RF_DATA: begin
          if (beat) begin
            if (beat_bad)                nxt = RF_FAIL;
            else if (count == LAST_BEAT) nxt = RF_DRAIN;
            else                         count <= count + 1'b1;
          end
        end
        // Final beat sits in the D-cache input register until no store competes.
        RF_DRAIN:  if (update_data_ready) nxt = RF_COMMIT;
        RF_COMMIT: nxt = RF_IDLE;
        RF_FAIL:   nxt = RF_IDLE;
        default:   nxt = RF_IDLE;
      endcase
      state            <= nxt;
      miss_ready       <= (nxt == RF_IDLE);
      busy             <= (nxt != RF_IDLE);
      done             <= (nxt == RF_COMMIT);
      err              <= (nxt == RF_FAIL);
      mem_arvalid      <= (nxt == RF_AR);
      update_tag_en    <= (nxt == RF_INVAL) || (nxt == RF_COMMIT);
      update_tag_valid <= (nxt == RF_COMMIT);
    end
  end

endmodule
`default_nettype wire
